// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the RV32I program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned INSTR_ALIGN          = 4;
    localparam int unsigned ALIGN_BITS           = $clog2(INSTR_ALIGN);
    localparam int unsigned INSTRET_W            = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select (JALR > JAL/branch > sequential) with alignment check.
module next_pc_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            br_taken,
    input  logic            jump,
    input  logic            jump_reg,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] rel_sum;
    logic [XLEN-1:0] seq_pc;

    assign jalr_sum = rs1 + imm;
    assign rel_sum  = pc + imm;
    assign seq_pc   = pc + XLEN'(INSTR_ALIGN);

    always_comb begin
        next_pc = seq_pc;
        if (jump_reg) begin
            next_pc = jalr_sum & ~XLEN'(1);
        end else if (jump || br_taken) begin
            next_pc = rel_sum;
        end
    end

    // Checked after the JALR bit0 clear, so only bit 1 can fire on that path.
    assign misaligned = |next_pc[ALIGN_BITS-1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute PC controller with misaligned-target trap and retire counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_ack,
    output logic                 instr_valid,
    input  logic                 exec_done,
    input  logic                 br_taken,
    input  logic                 jump,
    input  logic                 jump_reg,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      rs1,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus4,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            retire;
    logic            fault;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc         (pc),
        .imm        (imm),
        .rs1        (rs1),
        .br_taken   (br_taken),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the state-decoded strobes.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        retire      = 1'b0;
        fault       = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    if (misaligned) begin
                        fault      = 1'b1;
                        state_next = TRAP;
                    end else begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // pc only moves on a clean retire, so a trap leaves the faulting address visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            instret <= '0;
            trap    <= 1'b0;
        end else begin
            if (retire) begin
                pc      <= next_pc;
                instret <= instret + INSTRET_W'(1);
            end
            if (fault) begin
                trap <= 1'b1;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(INSTR_ALIGN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of control-flow vectors plus multi-cycle corner sequences.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        br_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] instret;

    int unsigned errors;
    int unsigned checks;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    typedef struct {
        logic        br;
        logic        j;
        logic        jr;
        logic [31:0] v_imm;
        logic [31:0] v_rs1;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[11];

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .br_taken    (br_taken),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .imm         (imm),
        .rs1         (rs1),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .trap        (trap),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        exec_done = 1'b0;
        br_taken  = 1'b0;
        jump      = 1'b0;
        jump_reg  = 1'b0;
        imm       = 32'h0;
        rs1       = 32'h0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        clear_ctrl();
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_trap", 32'(trap), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        rst_n = 1'b1;
        check("idle_cycle0_req", 32'(imem_req), 32'h0);
        step();
        check("fetch_cycle1_req", 32'(imem_req), 32'h1);
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
    endtask

    // Entered in FETCH; leaves in FETCH (or TRAP) one instruction later, two cycles minimum.
    task automatic run_instr(input logic br, input logic j, input logic jr,
                             input logic [31:0] i_imm, input logic [31:0] i_rs1,
                             input logic [31:0] exp_next, input logic exp_trap);
        check("fetch_req", 32'(imem_req), 32'h1);
        check("fetch_addr", imem_addr, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'h4);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("exec_valid", 32'(instr_valid), 32'h1);
        check("exec_req", 32'(imem_req), 32'h0);
        exec_done = 1'b1;
        br_taken  = br;
        jump      = j;
        jump_reg  = jr;
        imm       = i_imm;
        rs1       = i_rs1;
        step();
        clear_ctrl();
        if (exp_trap) begin
            check("trap_set", 32'(trap), 32'h1);
            check("trap_pc", pc, exp_pc);
            check("trap_instret", instret, exp_cnt);
            check("trap_req", 32'(imem_req), 32'h0);
        end else begin
            exp_pc  = exp_next;
            exp_cnt = exp_cnt + 32'h1;
            check("next_pc", pc, exp_pc);
            check("instret", instret, exp_cnt);
            check("refetch_req", 32'(imem_req), 32'h1);
            check("no_trap", 32'(trap), 32'h0);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        clear_ctrl();

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_000C};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0010};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0101, 32'h0000_0104};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0201, 32'h0000_0200};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0204};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FE00, 32'h0000_0000, 32'h0000_0004};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].br, vecs[i].j, vecs[i].jr, vecs[i].v_imm, vecs[i].v_rs1,
                      vecs[i].next, 1'b0);
        end

        // Slow memory: ack three cycles late, spurious exec_done in FETCH, spurious ack in EXEC.
        exec_done = 1'b1;
        jump      = 1'b1;
        imm       = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", 32'(imem_req), 32'h1);
            check("wait_addr", imem_addr, exp_pc);
            check("wait_instret", instret, exp_cnt);
        end
        clear_ctrl();
        imem_ack = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            check("slow_exec_valid", 32'(instr_valid), 32'h1);
            check("slow_exec_pc", pc, exp_pc);
            step();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        step();
        clear_ctrl();
        exp_pc  = exp_pc + 32'h4;
        exp_cnt = exp_cnt + 32'h1;
        check("slow_next_pc", pc, exp_pc);
        check("slow_instret", instret, exp_cnt);

        // Reset lands in EXEC with exec_done asserted and instret=5.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_pc + 32'h4, 1'b0);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("pre_rst_instret", instret, 32'h5);
        rst_n     = 1'b0;
        exec_done = 1'b1;
        jump      = 1'b1;
        imm       = 32'h40;
        step();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instret", instret, 32'h0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        clear_ctrl();
        imem_ack = 1'b1;
        step();
        check("rst_ack_state", 32'(dut.state), 32'(IDLE));
        imem_ack = 1'b0;

        // Misaligned branch target at pc=0x20.
        do_reset();
        run_instr(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0020, 1'b0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1);
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("trap_hold", 32'(trap), 32'h1);
            check("trap_hold_pc", pc, 32'h0000_0020);
            check("trap_hold_req", 32'(imem_req), 32'h0);
            check("trap_hold_valid", 32'(instr_valid), 32'h0);
            check("trap_hold_instret", instret, 32'h1);
        end
        clear_ctrl();
        imem_ack = 1'b0;

        // All three selects high: JALR wins, target 0x102 is half-word aligned only.
        do_reset();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        jump_reg = 1'b1;
        jump     = 1'b1;
        br_taken = 1'b1;
        rs1      = 32'h0000_0101;
        imm      = 32'h0000_0002;
        #1;
        check("prio_target", dut.next_pc, 32'h0000_0102);
        check("prio_misaligned", 32'(dut.misaligned), 32'h1);
        exec_done = 1'b1;
        step();
        clear_ctrl();
        check("prio_trap", 32'(trap), 32'h1);
        check("prio_trap_pc", pc, 32'h0);
        check("prio_trap_instret", instret, 32'h0);

        // Retire counter wrap.
        do_reset();
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        exp_cnt = 32'hFFFF_FFFF;
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
